txn_done_multi: RTL and testbench
=================================

# txn_done_multi

Multi-channel, counted successor to the single-handshake `txn_done` tracker. Arms on `start`, latches a beat target, counts `valid & ready` handshakes independently on each of `NUM_CH` channels, and flags each channel and the whole group when every channel has reached the target. Used by sequencers that issue multi-beat transfers on parallel interfaces (e.g. per-bank SRAM writes, multi-lane pixel pushes) and must wait for all of them before advancing.

## Interface

- `NUM_CH`, 2: number of independent handshake channels (≥1).
- `CNT_W`, 8: width of the beat target and per-channel counters.
- `COMB_DONE`, 1: 1 adds a combinational path so `ch_done`/`all_done` rise in the cycle of the final handshake; 0 gives registered-only outputs.

- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  arm the tracker; honoured only in IDLE.
- `target`  in  CNT_W  handshakes required per channel; sampled only when `start` is honoured.
- `clear`  in  1  synchronous abort/acknowledge; returns the block to IDLE.
- `valid`  in  NUM_CH  per-channel valid.
- `ready`  in  NUM_CH  per-channel ready.
- `busy`  out  1  high in ARMED.
- `ch_done`  out  NUM_CH  channel i has completed `target` handshakes.
- `all_done`  out  1  AND of `ch_done`.
- `overflow`  out  1  sticky; a handshake arrived on a channel already at target.

## Operation

- States: IDLE, ARMED, DONE.
- IDLE: counters held at 0, handshakes ignored. `start` latches `target`. If `target == 0`, go to DONE; otherwise go to ARMED.
- ARMED: on each edge where `valid[i] & ready[i]`, `cnt[i]` increments. When `cnt[i]` reaches the target, `done_ff[i]` is set and `cnt[i]` stops incrementing. Go to DONE on the edge at which the last outstanding channel completes, including the case where several channels complete on the same edge.
- DONE: all `done_ff` are set and held. Further handshakes leave the counters unchanged.
- `overflow` sets on any edge in ARMED or DONE where `valid[i] & ready[i]` and channel i is already complete. It stays set until `clear` or `reset`.
- `clear` in any state: next state is IDLE, and all counters, `done_ff` and `overflow` go to 0. `clear` wins over a simultaneous `start` or handshake; that handshake is not counted and sets no flag.
- `start` in ARMED or DONE is ignored, and `target` is not re-sampled.
- Outputs:
  - `ch_done[i] = done_ff[i] | (COMB_DONE & state==ARMED & !clear & valid[i] & ready[i] & cnt[i]==target_q-1)`.
  - `all_done = &ch_done`.
- Counter width is CNT_W. Counters cannot wrap because they saturate at `target_q`. `target = 2^CNT_W-1` is legal.

## Timing

- Reset values (asynchronous): state IDLE, `busy`=0, `ch_done`=0, `all_done`=0, `overflow`=0, counters 0, `target_q` 0.
- While `reset` is high the combinational path is suppressed because state is IDLE, so outputs read 0 even with `valid & ready` high.
- Reset asserted mid-ARMED aborts the operation immediately. Nothing is retained.
- `start` accepted at edge N gives `busy`=1 from edge N. With target 0, `all_done`=1 from edge N and `busy` stays 0.
- Final handshake sampled at edge N:
  - COMB_DONE=1: `ch_done[i]`/`all_done` are high during the cycle before edge N, and registered from edge N on.
  - COMB_DONE=0: they are high from edge N.
- State reaches DONE (`busy`=0) at edge N in both modes.
- `clear` sampled at edge N makes all outputs 0 from edge N. The combinational term is gated by `!clear`.
- One handshake per channel per cycle maximum. The block never drives `ready`.

## Test plan

Bench uses NUM_CH=2, CNT_W=4.

- **Reset with live handshake:** reset held with `valid=ready=2'b11` -> `ch_done=0`, `all_done=0`, `busy=0`. Release reset with no `start` and keep `valid=ready=11` for 3 cycles -> counters stay 0 and no flags rise.
- **Basic count, COMB_DONE=1:** `start`, `target=3`, then `valid=ready=11` for 3 cycles -> `ch_done=11` and `all_done=1` in the 3rd handshake cycle. `busy` drops at that edge, and `all_done` stays 1 with inputs idle.
- **Skewed channels:** `target=2`, ch0 handshakes on cycles 1 and 2, ch1 on cycles 4 and 6 -> `ch_done=01` after ch0's 2nd beat. `all_done=1` only at ch1's 2nd beat.
- **Overflow, then clear:** in DONE, one more ch1 handshake -> `overflow=1`, counts unchanged. `clear` together with `start` and a handshake -> all outputs 0, state IDLE, `start` not taken.
- **Edge targets:** `target=0` -> `all_done=1` the edge after `start`, `busy=0`. `target=15` with 15 handshakes per channel -> done with no wrap and `overflow=0`.
- **COMB_DONE=0 and mid-run reset:**
  - COMB_DONE=0, `target=1`: single handshake at edge N -> `all_done` is 0 before edge N and 1 after.
  - Any mode: assert `reset` after 1 of 3 beats -> immediate IDLE. A later `start` needs the full 3 beats.

Source files
------------

// File: rtl/txn_done_multi_if.sv
// rtl/txn_done_multi_if.sv - control, handshake and status bundle for txn_done_multi
interface txn_done_multi_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 8
);
   logic              start;
   logic [CNT_W-1:0]  target;
   logic              clear;
   logic [NUM_CH-1:0] valid;
   logic [NUM_CH-1:0] ready;
   logic              busy;
   logic [NUM_CH-1:0] ch_done;
   logic              all_done;
   logic              overflow;

   modport master (
      output start, target, clear, valid, ready,
      input  busy, ch_done, all_done, overflow
   );

   modport slave (
      input  start, target, clear, valid, ready,
      output busy, ch_done, all_done, overflow
   );
endinterface

// File: rtl/txn_done_multi.sv
// rtl/txn_done_multi.sv - counts per-channel handshakes to a latched target and flags group completion
module txn_done_multi #(
   parameter int NUM_CH    = 2,
   parameter int CNT_W     = 8,
   parameter bit COMB_DONE = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   txn_done_multi_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  target_q;
   logic [CNT_W-1:0]  tgt_m1;
   logic [CNT_W-1:0]  cnt [NUM_CH];
   logic [NUM_CH-1:0] done_ff;
   logic [NUM_CH-1:0] hs;
   logic [NUM_CH-1:0] done_set;
   logic [NUM_CH-1:0] done_nxt;
   logic [NUM_CH-1:0] comb_hit;
   logic [NUM_CH-1:0] ch_done;
   logic              overflow_q;
   logic              busy_q;

   // done_set marks channels whose handshake this cycle is the final beat
   always_comb begin
      hs     = bus.valid & bus.ready;
      tgt_m1 = target_q - 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         done_set[i] = hs[i] & ~done_ff[i] & (cnt[i] == tgt_m1);
      end
      done_nxt = done_ff | done_set;
      comb_hit = '0;
      if (COMB_DONE && (state == ARMED) && !bus.clear) begin
         comb_hit = done_set;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         target_q   <= '0;
         done_ff    <= '0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      end else if (bus.clear) begin
         state      <= IDLE;
         done_ff    <= '0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  target_q <= bus.target;
                  if (bus.target == '0) begin
                     state   <= DONE;
                     done_ff <= '1;
                  end else begin
                     state  <= ARMED;
                     busy_q <= 1'b1;
                  end
               end
            end
            ARMED: begin
               for (int i = 0; i < NUM_CH; i++) begin
                  if (hs[i] && !done_ff[i]) cnt[i] <= cnt[i] + 1'b1;
               end
               done_ff <= done_nxt;
               if (|(hs & done_ff)) overflow_q <= 1'b1;
               if (&done_nxt) begin
                  state  <= DONE;
                  busy_q <= 1'b0;
               end
            end
            DONE: begin
               if (|(hs & done_ff)) overflow_q <= 1'b1;
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign ch_done      = done_ff | comb_hit;
   assign bus.ch_done  = ch_done;
   assign bus.all_done = &ch_done;
   assign bus.busy     = busy_q;
   assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_txn_done_multi.sv
// tb/tb_txn_done_multi.sv - directed checks of txn_done_multi with and without the combinational done path
module tb_txn_done_multi;
   logic       clk = 1'b0;
   logic       reset;
   logic       start, clear;
   logic [3:0] target;
   logic [1:0] valid, ready;
   int         pass_cnt = 0;
   int         total    = 0;

   always #5 clk = ~clk;

   txn_done_multi_if #(.NUM_CH(2), .CNT_W(4)) ia ();
   txn_done_multi_if #(.NUM_CH(2), .CNT_W(4)) ib ();

   assign ia.start = start;  assign ib.start = start;
   assign ia.target = target; assign ib.target = target;
   assign ia.clear = clear;  assign ib.clear = clear;
   assign ia.valid = valid;  assign ib.valid = valid;
   assign ia.ready = ready;  assign ib.ready = ready;

   txn_done_multi #(.NUM_CH(2), .CNT_W(4), .COMB_DONE(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ia.slave));
   txn_done_multi #(.NUM_CH(2), .CNT_W(4), .COMB_DONE(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ib.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hs(input logic [1:0] v);
      valid = v;
      ready = v;
   endtask

   task automatic do_clear();
      clear = 1'b1; tick(); clear = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; clear = 1'b0; target = 4'd0; hs(2'b11);
      tick(); tick(); #1;
      total++; if (ia.ch_done !== 2'b00 || ia.all_done !== 1'b0 || ia.busy !== 1'b0) $display("FAIL reset_a ch_done=%b all_done=%b busy=%b want 00/0/0", ia.ch_done, ia.all_done, ia.busy); else pass_cnt++;
      total++; if (ib.ch_done !== 2'b00 || ib.all_done !== 1'b0 || ib.busy !== 1'b0) $display("FAIL reset_b ch_done=%b all_done=%b busy=%b want 00/0/0", ib.ch_done, ib.all_done, ib.busy); else pass_cnt++;
      reset = 1'b0;
      tick(); tick(); tick();
      total++; if (ia.ch_done !== 2'b00 || ia.all_done !== 1'b0 || ia.overflow !== 1'b0 || ia.busy !== 1'b0) $display("FAIL idle_hs ch_done=%b all_done=%b ovf=%b busy=%b want 00/0/0/0", ia.ch_done, ia.all_done, ia.overflow, ia.busy); else pass_cnt++;
      hs(2'b00);
   endtask

   task automatic test_basic();
      target = 4'd3; start = 1'b1; tick(); start = 1'b0;
      total++; if (ia.busy !== 1'b1) $display("FAIL basic_busy busy=%b want 1", ia.busy); else pass_cnt++;
      hs(2'b11); tick(); tick(); #1;
      total++; if (ia.ch_done !== 2'b11 || ia.all_done !== 1'b1 || ia.busy !== 1'b1) $display("FAIL basic_comb ch_done=%b all_done=%b busy=%b want 11/1/1", ia.ch_done, ia.all_done, ia.busy); else pass_cnt++;
      total++; if (ib.ch_done !== 2'b00 || ib.all_done !== 1'b0) $display("FAIL basic_reg_early ch_done=%b all_done=%b want 00/0", ib.ch_done, ib.all_done); else pass_cnt++;
      tick(); hs(2'b00); #1;
      total++; if (ia.ch_done !== 2'b11 || ia.all_done !== 1'b1 || ia.busy !== 1'b0) $display("FAIL basic_done_a ch_done=%b all_done=%b busy=%b want 11/1/0", ia.ch_done, ia.all_done, ia.busy); else pass_cnt++;
      total++; if (ib.all_done !== 1'b1 || ib.busy !== 1'b0) $display("FAIL basic_done_b all_done=%b busy=%b want 1/0", ib.all_done, ib.busy); else pass_cnt++;
      tick(); tick();
      total++; if (ia.all_done !== 1'b1 || ia.overflow !== 1'b0) $display("FAIL basic_hold all_done=%b ovf=%b want 1/0", ia.all_done, ia.overflow); else pass_cnt++;
      do_clear(); #1;
      total++; if (ia.ch_done !== 2'b00 || ia.all_done !== 1'b0 || ia.busy !== 1'b0) $display("FAIL basic_clear ch_done=%b all_done=%b busy=%b want 00/0/0", ia.ch_done, ia.all_done, ia.busy); else pass_cnt++;
   endtask

   task automatic test_skewed();
      target = 4'd2; start = 1'b1; tick(); start = 1'b0;
      hs(2'b01); tick();
      #1;
      total++; if (ia.ch_done !== 2'b01 || ia.all_done !== 1'b0) $display("FAIL skew_comb0 ch_done=%b all_done=%b want 01/0", ia.ch_done, ia.all_done); else pass_cnt++;
      tick(); hs(2'b00); #1;
      total++; if (ib.ch_done !== 2'b01 || ib.all_done !== 1'b0 || ib.busy !== 1'b1) $display("FAIL skew_ch0 ch_done=%b all_done=%b busy=%b want 01/0/1", ib.ch_done, ib.all_done, ib.busy); else pass_cnt++;
      tick();
      hs(2'b10); tick(); hs(2'b00); #1;
      total++; if (ia.ch_done !== 2'b01 || ia.all_done !== 1'b0) $display("FAIL skew_ch1_first ch_done=%b all_done=%b want 01/0", ia.ch_done, ia.all_done); else pass_cnt++;
      tick();
      hs(2'b10); #1;
      total++; if (ia.all_done !== 1'b1 || ib.all_done !== 1'b0) $display("FAIL skew_last_comb a=%b b=%b want 1/0", ia.all_done, ib.all_done); else pass_cnt++;
      tick(); hs(2'b00); #1;
      total++; if (ia.all_done !== 1'b1 || ib.all_done !== 1'b1 || ia.busy !== 1'b0 || ib.busy !== 1'b0) $display("FAIL skew_done a=%b b=%b busy_a=%b busy_b=%b want 1/1/0/0", ia.all_done, ib.all_done, ia.busy, ib.busy); else pass_cnt++;
   endtask

   task automatic test_overflow_clear();
      hs(2'b10); tick(); hs(2'b00); #1;
      total++; if (ia.overflow !== 1'b1 || ib.overflow !== 1'b1) $display("FAIL ovf_set a=%b b=%b want 1/1", ia.overflow, ib.overflow); else pass_cnt++;
      total++; if (ia.all_done !== 1'b1 || ia.busy !== 1'b0) $display("FAIL ovf_hold all_done=%b busy=%b want 1/0", ia.all_done, ia.busy); else pass_cnt++;
      clear = 1'b1; start = 1'b1; target = 4'd5; hs(2'b11); tick(); #1;
      total++; if (ia.ch_done !== 2'b00 || ia.all_done !== 1'b0 || ia.overflow !== 1'b0 || ia.busy !== 1'b0) $display("FAIL clr_start ch_done=%b all_done=%b ovf=%b busy=%b want 00/0/0/0", ia.ch_done, ia.all_done, ia.overflow, ia.busy); else pass_cnt++;
      clear = 1'b0; start = 1'b0; hs(2'b00); tick();
      total++; if (ia.busy !== 1'b0 || ib.busy !== 1'b0 || ib.overflow !== 1'b0) $display("FAIL clr_no_start busy_a=%b busy_b=%b ovf_b=%b want 0/0/0", ia.busy, ib.busy, ib.overflow); else pass_cnt++;
   endtask

   task automatic test_edge_targets();
      target = 4'd0; start = 1'b1; tick(); start = 1'b0;
      total++; if (ia.all_done !== 1'b1 || ia.ch_done !== 2'b11 || ia.busy !== 1'b0) $display("FAIL tgt0_a all_done=%b ch_done=%b busy=%b want 1/11/0", ia.all_done, ia.ch_done, ia.busy); else pass_cnt++;
      total++; if (ib.all_done !== 1'b1 || ib.busy !== 1'b0) $display("FAIL tgt0_b all_done=%b busy=%b want 1/0", ib.all_done, ib.busy); else pass_cnt++;
      do_clear();
      target = 4'd15; start = 1'b1; tick(); start = 1'b0;
      hs(2'b11);
      for (int i = 0; i < 14; i++) tick();
      total++; if (ib.all_done !== 1'b0 || ib.busy !== 1'b1 || ia.all_done !== 1'b1) $display("FAIL tgt15_pre b_done=%b b_busy=%b a_done=%b want 0/1/1", ib.all_done, ib.busy, ia.all_done); else pass_cnt++;
      tick(); hs(2'b00); #1;
      total++; if (ia.all_done !== 1'b1 || ib.all_done !== 1'b1 || ia.busy !== 1'b0 || ia.overflow !== 1'b0 || ib.overflow !== 1'b0) $display("FAIL tgt15_done a=%b b=%b busy=%b ovf_a=%b ovf_b=%b want 1/1/0/0/0", ia.all_done, ib.all_done, ia.busy, ia.overflow, ib.overflow); else pass_cnt++;
      do_clear();
   endtask

   task automatic test_comb0_single();
      target = 4'd1; start = 1'b1; tick(); start = 1'b0;
      hs(2'b11); #1;
      total++; if (ib.all_done !== 1'b0 || ia.all_done !== 1'b1) $display("FAIL single_pre b=%b a=%b want 0/1", ib.all_done, ia.all_done); else pass_cnt++;
      tick(); hs(2'b00); #1;
      total++; if (ib.all_done !== 1'b1 || ib.ch_done !== 2'b11 || ib.busy !== 1'b0) $display("FAIL single_post all_done=%b ch_done=%b busy=%b want 1/11/0", ib.all_done, ib.ch_done, ib.busy); else pass_cnt++;
      do_clear();
   endtask

   task automatic test_midrun_reset();
      target = 4'd3; start = 1'b1; tick(); start = 1'b0;
      hs(2'b11); tick(); hs(2'b00);
      #1 reset = 1'b1; #1;
      total++; if (ia.busy !== 1'b0 || ib.busy !== 1'b0 || ia.ch_done !== 2'b00) $display("FAIL async_reset busy_a=%b busy_b=%b ch_done=%b want 0/0/00", ia.busy, ib.busy, ia.ch_done); else pass_cnt++;
      tick(); reset = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      hs(2'b11); tick(); tick();
      total++; if (ib.all_done !== 1'b0 || ib.busy !== 1'b1) $display("FAIL reset_no_retain all_done=%b busy=%b want 0/1", ib.all_done, ib.busy); else pass_cnt++;
      tick(); hs(2'b00); #1;
      total++; if (ia.all_done !== 1'b1 || ib.all_done !== 1'b1 || ib.busy !== 1'b0) $display("FAIL reset_full_run a=%b b=%b busy=%b want 1/1/0", ia.all_done, ib.all_done, ib.busy); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_skewed();
      test_overflow_clear();
      test_edge_targets();
      test_comb0_single();
      test_midrun_reset();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
